// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable binary down-counter/timer with a one-clock
// terminal-count pulse, one-shot and auto-reload (periodic) modes.
// Optional feature: define PRESCALE_EN to add a prescaler so that q only
// decrements on every PRESC_DIV-th enabled edge while running.
module down_counter_timer #(
    parameter int WIDTH     = 8,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;
    logic             dec_tick;

    // Reject parameter values the counter cannot honour.
    if (WIDTH < 2 || PRESC_DIV < 2) begin : g_param_check
        $error("down_counter_timer: WIDTH and PRESC_DIV must both be >= 2");
    end

`ifdef PRESCALE_EN
    localparam int PRESC_W = $clog2(PRESC_DIV);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_next;

    // A decrement is allowed only when the prescaler has counted a full period.
    assign dec_tick = (presc_cnt == PRESC_W'(PRESC_DIV - 1));

    // Prescaler advances on enabled RUN edges, restarts on clear or load, holds otherwise.
    always_comb begin
        presc_next = presc_cnt;
        if (sync_clr || load) begin
            presc_next = '0;
        end else if (state == RUN && enable) begin
            presc_next = dec_tick ? '0 : presc_cnt + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_next;
        end
    end
`else
    // Without the prescaler every enabled RUN edge is a decrement edge.
    assign dec_tick = 1'b1;
`endif

    // Next-state and datapath decisions, priority sync_clr > load > enable.
    always_comb begin
        state_next  = state;
        q_next      = q;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (sync_clr) begin
            state_next  = IDLE;
            q_next      = '0;
            reload_next = '0;
        end else if (load) begin
            q_next      = d;
            reload_next = d;
            state_next  = (d != '0) ? RUN : IDLE;
        end else if (state == RUN && enable && dec_tick) begin
            if (q > WIDTH'(1)) begin
                q_next = q - 1'b1;
            end else if (q == WIDTH'(1)) begin
                tc_next = 1'b1;
                if (auto_reload) begin
                    q_next = reload_reg;
                end else begin
                    q_next     = '0;
                    state_next = IDLE;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Count, reload value and terminal-count pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            q          <= q_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed and randomized stimulus for down_counter_timer,
// compared every cycle against a behavioural model of the counter's rules.
// Honours PRESCALE_EN the same way as the design.
module tb_down_counter_timer;

    localparam int WIDTH = 8;
    localparam int PDIV  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sync_clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state: plain integers, busy as a flag.
    int m_q;
    int m_reload;
    int m_presc;
    bit m_busy;
    bit m_tc;
    int tc_seen;

    down_counter_timer #(
        .WIDTH    (WIDTH),
        .PRESC_DIV(PDIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .load       (load),
        .d          (d),
        .enable     (enable),
        .auto_reload(auto_reload),
        .q          (q),
        .tc         (tc),
        .busy       (busy)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".q"},    32'(q),    32'(m_q));
        checkOutput({tag, ".tc"},   32'(tc),   32'(m_tc));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    task automatic modelReset();
        m_q      = 0;
        m_reload = 0;
        m_presc  = 0;
        m_busy   = 1'b0;
        m_tc     = 1'b0;
    endtask

    // One clock edge of the counter's documented behaviour.
    task automatic modelStep(input bit sc, input bit ld, input int dv,
                             input bit en, input bit ar);
        bit fire;
        m_tc = 1'b0;
        if (sc) begin
            m_q = 0; m_reload = 0; m_busy = 1'b0; m_presc = 0;
        end else if (ld) begin
            m_q = dv; m_reload = dv; m_busy = (dv != 0); m_presc = 0;
        end else if (m_busy && en) begin
`ifdef PRESCALE_EN
            fire    = (m_presc == PDIV - 1);
            m_presc = fire ? 0 : m_presc + 1;
`else
            fire = 1'b1;
`endif
            if (fire) begin
                if (m_q > 1) begin
                    m_q = m_q - 1;
                end else begin
                    m_tc = 1'b1;
                    if (ar) begin
                        m_q = m_reload;
                    end else begin
                        m_q    = 0;
                        m_busy = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit sc, input bit ld,
                                 input int dv, input bit en, input bit ar);
        sync_clr    = sc;
        load        = ld;
        d           = WIDTH'(dv);
        enable      = en;
        auto_reload = ar;
        modelStep(sc, ld, dv, en, ar);
        @(posedge clk);
        #1;
        if (tc === 1'b1) tc_seen++;
        checkAll(tag);
    endtask

    // Assert reset between edges, check outputs before any edge, then release.
    task automatic asyncReset(input string tag);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int scale;
`ifdef PRESCALE_EN
        scale = PDIV;
`else
        scale = 1;
`endif
        rst_n = 1'b0; sync_clr = 1'b0; load = 1'b0; d = '0;
        enable = 1'b0; auto_reload = 1'b0;
        modelReset();
        #1;
        checkAll("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] async reset mid-count");
        applyStimulus("t1_load5", 0, 1, 5, 0, 0);
        checkOutput("t1_q_is_5", 32'(q), 32'd5);
        asyncReset("t1_async");

        $display("[TB] one-shot d=3");
        applyStimulus("t2_load3", 0, 1, 3, 1, 0);
        tc_seen = 0;
        for (int i = 0; i < 4 * scale; i++) applyStimulus("t2_run", 0, 0, 0, 1, 0);
        checkOutput("t2_final_q", 32'(q), 32'd0);
        checkOutput("t2_tc_count", 32'(tc_seen), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus("t2_idle_nowrap", 0, 0, 0, 1, 0);

        $display("[TB] auto-reload d=3");
        applyStimulus("t3_load3", 0, 1, 3, 1, 1);
        tc_seen = 0;
        for (int i = 0; i < 9 * scale; i++) applyStimulus("t3_run", 0, 0, 0, 1, 1);
        checkOutput("t3_final_q", 32'(q), 32'd3);
        checkOutput("t3_tc_count", 32'(tc_seen), 32'd3);
        checkOutput("t3_busy", 32'(busy), 32'd1);

        $display("[TB] enable toggling and sync_clr with load");
        applyStimulus("t4_load5", 0, 1, 5, 1, 0);
        for (int i = 0; i < scale; i++) applyStimulus("t4_en1", 0, 0, 0, 1, 0);
        applyStimulus("t4_en0", 0, 0, 0, 0, 0);
        for (int i = 0; i < scale; i++) applyStimulus("t4_en1b", 0, 0, 0, 1, 0);
        checkOutput("t4_q_is_3", 32'(q), 32'd3);
        applyStimulus("t4_clr_load", 1, 1, 9, 1, 0);

        $display("[TB] load zero and full scale");
        applyStimulus("t5_load0", 0, 1, 0, 1, 0);
        applyStimulus("t5_loadFF", 0, 1, 255, 1, 0);
        tc_seen = 0;
        for (int i = 0; i < 255 * scale; i++) applyStimulus("t5_run", 0, 0, 0, 1, 0);
        checkOutput("t5_final_q", 32'(q), 32'd0);
        checkOutput("t5_tc_count", 32'(tc_seen), 32'd1);

        $display("[TB] load colliding with terminal decrement");
        applyStimulus("t7_load2", 0, 1, 2, 1, 1);
        for (int i = 0; i < scale; i++) applyStimulus("t7_to1", 0, 0, 0, 1, 1);
        for (int i = 0; i < scale - 1; i++) applyStimulus("t7_pre", 0, 0, 0, 1, 1);
        applyStimulus("t7_load_wins", 0, 1, 7, 1, 1);
        checkOutput("t7_q_is_7", 32'(q), 32'd7);

        $display("[TB] randomized stimulus");
        for (int i = 0; i < 4000; i++) begin
            bit sc, ld, en, ar;
            int dv;
            int sel;
            if ($urandom_range(0, 199) == 0) begin
                asyncReset("rand_async");
            end else begin
                sc  = ($urandom_range(0, 99) < 2);
                ld  = ($urandom_range(0, 99) < 6);
                en  = ($urandom_range(0, 99) < 75);
                ar  = $urandom_range(0, 1) == 1;
                sel = $urandom_range(0, 9);
                if (sel == 0)      dv = 0;
                else if (sel == 1) dv = 255;
                else if (sel < 6)  dv = $urandom_range(1, 6);
                else               dv = $urandom_range(0, 255);
                applyStimulus("rand", sc, ld, dv, en, ar);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
